// File: rtl/ram_stream_writer.sv
// Stream-to-RAM writer: fills a RAM from a valid/ready word stream starting at a
// commanded base address, with a registered read-first read port.
// Optional macro WRITER_CHECKSUM_EN adds an XOR checksum of the burst's words.
module ram_stream_writer #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
`ifdef WRITER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH + 1)'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

`ifdef WRITER_CHECKSUM_EN
  function automatic logic [DATA_WIDTH-1:0] xor_acc(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] word
  );
    xor_acc = acc ^ word;
  endfunction

  logic [DATA_WIDTH-1:0] checksum_r;
`endif

  state_t                  state_r;
  state_t                  state_s;
  logic [ADDR_WIDTH-1:0]   ptr_r;
  logic [ADDR_WIDTH:0]     remaining_r;
  logic [ADDR_WIDTH:0]     wr_count_r;
  logic [DATA_WIDTH-1:0]   rd_data_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
  logic                    accept_start_s;
  logic                    xfer_s;

  assign accept_start_s = (state_r == ST_IDLE) && start;
  assign xfer_s         = (state_r == ST_WRITE) && wr_valid;

  // Outputs are decoded straight from the state register.
  assign wr_ready = (state_r == ST_WRITE);
  assign busy     = (state_r == ST_WRITE);
  assign done     = (state_r == ST_DONE);
  assign wr_count = wr_count_r;
  assign rd_data  = rd_data_r;
`ifdef WRITER_CHECKSUM_EN
  assign checksum = checksum_r;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a zero-length burst goes straight to DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (len != CNT_ZERO) begin
            state_s = ST_WRITE;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (abort || (xfer_s && (remaining_r == CNT_ONE))) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Burst pointer, remaining count and written-word count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r       <= '0;
      remaining_r <= '0;
      wr_count_r  <= '0;
    end else if (accept_start_s) begin
      ptr_r       <= base_addr;
      remaining_r <= len;
      wr_count_r  <= CNT_ZERO;
    end else if (xfer_s) begin
      ptr_r       <= ptr_r + PTR_ONE;
      remaining_r <= remaining_r - CNT_ONE;
      wr_count_r  <= wr_count_r + CNT_ONE;
    end else begin
      ptr_r       <= ptr_r;
      remaining_r <= remaining_r;
      wr_count_r  <= wr_count_r;
    end
  end

`ifdef WRITER_CHECKSUM_EN
  // XOR checksum of the words transferred since the last accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_r <= '0;
    end else if (accept_start_s) begin
      checksum_r <= '0;
    end else if (xfer_s) begin
      checksum_r <= xor_acc(checksum_r, wr_data);
    end else begin
      checksum_r <= checksum_r;
    end
  end
`endif

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      mem_r[ptr_r] <= wr_data;
    end
  end

  // Registered read port; a same-cycle write to rd_addr returns the old word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_r <= '0;
    end else begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

endmodule

// File: tb/tb_ram_stream_writer.sv
// Self-checking bench for ram_stream_writer: scenario tasks plus a reference RAM
// model whose expected read data flows through a scoreboard queue.
module tb_ram_stream_writer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] base_addr = 3'd0;
  logic [3:0] len = 4'd0;
  logic       abort = 1'b0;
  logic [1:0] wr_data = 2'd0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       busy;
  logic       done;
  logic [3:0] wr_count;
  logic [2:0] rd_addr = 3'd0;
  logic [1:0] rd_data;
`ifdef WRITER_CHECKSUM_EN
  logic [1:0] checksum;
`endif

  ram_stream_writer #(.ADDR_WIDTH(3), .DATA_WIDTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .len(len), .abort(abort), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .busy(busy), .done(done), .wr_count(wr_count),
    .rd_addr(rd_addr),
`ifdef WRITER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference RAM model
  logic [1:0] model_mem [8];
  bit         model_known [8];
  logic [1:0] model_ck;

  // Burst stimulus and observations
  logic [1:0] stim_words [16];
  bit         stim_pat [16];
  int         pat_len;
  int         abort_at;
  int         restart_cyc;
  int         done_cycle;
  int         xfers;
  int         ready_bad;
  logic [1:0] rd_at2;

  typedef struct { bit known; logic [1:0] data; int addr; } exp_t;
  exp_t sb [$];

  task automatic run_burst(input int base, input int n);
    int pi;
    int mptr;
    pi = 0;
    mptr = base;
    done_cycle = -1;
    xfers = 0;
    ready_bad = 0;
    model_ck = 2'd0;
    @(negedge clk);
    start = 1'b1; base_addr = base[2:0]; len = n[3:0]; wr_valid = 1'b0; abort = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_cyc);
      if (cyc == 2) rd_at2 = rd_data;
      if (done === 1'b1) begin
        done_cycle = cyc;
        break;
      end
      if (wr_ready !== 1'b1 || busy !== 1'b1) ready_bad++;
      wr_valid = (xfers < n && (abort_at < 0 || xfers <= abort_at)) ? stim_pat[pi % pat_len] : 1'b0;
      pi++;
      wr_data = stim_words[xfers % 16];
      abort = wr_valid && (xfers == abort_at);
      if (wr_valid) begin
        model_mem[mptr % 8] = wr_data;
        model_known[mptr % 8] = 1'b1;
        model_ck = model_ck ^ wr_data;
        mptr++;
        xfers++;
      end
    end
    start = 1'b0; wr_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic set_stim(input logic [1:0] w0, input logic [1:0] w1, input logic [1:0] w2,
                          input logic [1:0] w3);
    for (int i = 0; i < 16; i++) stim_words[i] = 2'd0;
    stim_words[0] = w0; stim_words[1] = w1; stim_words[2] = w2; stim_words[3] = w3;
    for (int i = 0; i < 16; i++) stim_pat[i] = 1'b1;
    pat_len = 1;
    abort_at = -1;
    restart_cyc = 0;
  endtask

  task automatic test_readback(input string tag);
    exp_t e;
    for (int a = 0; a <= 8; a++) begin
      @(negedge clk);
      if (a > 0) begin
        e = sb.pop_front();
        if (e.known) begin
          checks++;
          if (rd_data !== e.data) begin
            errors++;
            $display("FAIL %s rd[%0d]: got %0d expected %0d", tag, e.addr, rd_data, e.data);
          end
        end
      end
      if (a < 8) begin
        rd_addr = a[2:0];
        e.known = model_known[a]; e.data = model_mem[a]; e.addr = a;
        sb.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if ({busy, done, wr_ready, wr_count, rd_data} !== 9'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b ready=%b count=%0d rd=%0d expected all 0",
               busy, done, wr_ready, wr_count, rd_data);
    end
  endtask

  task automatic test_fill_all();
    set_stim(2'd1, 2'd2, 2'd1, 2'd3);
    stim_words[4] = 2'd0; stim_words[5] = 2'd2; stim_words[6] = 2'd3; stim_words[7] = 2'd1;
    run_burst(5, 8);
    checks++;
    if (done_cycle != 9 || wr_count !== 4'd8) begin
      errors++;
      $display("FAIL fill_all: done_cycle=%0d count=%0d expected 9 and 8", done_cycle, wr_count);
    end
`ifdef WRITER_CHECKSUM_EN
    checks++;
    if (checksum !== model_ck) begin
      errors++;
      $display("FAIL fill_checksum: got %0d expected %0d", checksum, model_ck);
    end
`endif
    test_readback("fill_all");
  endtask

  task automatic test_basic();
    logic [1:0] old2;
    old2 = model_mem[2];
    rd_addr = 3'd2;
    set_stim(2'd1, 2'd2, 2'd3, 2'd0);
    run_burst(2, 4);
    checks++;
    if (done_cycle != 5 || wr_count !== 4'd4 || ready_bad != 0) begin
      errors++;
      $display("FAIL basic: done_cycle=%0d count=%0d ready_bad=%0d expected 5, 4, 0",
               done_cycle, wr_count, ready_bad);
    end
    checks++;
    if (rd_at2 !== old2) begin
      errors++;
      $display("FAIL read_first: got %0d expected %0d", rd_at2, old2);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wr_count !== 4'd4) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b count=%0d expected 0, 0, 4", done, busy, wr_count);
    end
`ifdef WRITER_CHECKSUM_EN
    checks++;
    if (checksum !== model_ck) begin
      errors++;
      $display("FAIL basic_checksum: got %0d expected %0d", checksum, model_ck);
    end
`endif
    test_readback("basic");
  endtask

  task automatic test_wrap();
    set_stim(2'd3, 2'd1, 2'd2, 2'd0);
    run_burst(6, 3);
    checks++;
    if (done_cycle != 4 || wr_count !== 4'd3) begin
      errors++;
      $display("FAIL wrap: done_cycle=%0d count=%0d expected 4 and 3", done_cycle, wr_count);
    end
    test_readback("wrap");
  endtask

  task automatic test_backpressure();
    set_stim(2'd2, 2'd2, 2'd1, 2'd0);
    stim_pat[0] = 1'b1; stim_pat[1] = 1'b0; stim_pat[2] = 1'b0;
    stim_pat[3] = 1'b1; stim_pat[4] = 1'b0; stim_pat[5] = 1'b1;
    pat_len = 6;
    run_burst(1, 3);
    checks++;
    if (done_cycle != 7 || wr_count !== 4'd3) begin
      errors++;
      $display("FAIL backpressure: done_cycle=%0d count=%0d expected 7 and 3", done_cycle, wr_count);
    end
`ifdef WRITER_CHECKSUM_EN
    checks++;
    if (checksum !== model_ck) begin
      errors++;
      $display("FAIL bp_checksum: got %0d expected %0d", checksum, model_ck);
    end
`endif
    test_readback("backpressure");
  endtask

  task automatic test_len_zero();
    set_stim(2'd3, 2'd3, 2'd3, 2'd3);
    run_burst(0, 0);
    checks++;
    if (done_cycle != 1 || wr_count !== 4'd0) begin
      errors++;
      $display("FAIL len_zero: done_cycle=%0d count=%0d expected 1 and 0", done_cycle, wr_count);
    end
    test_readback("len_zero");
  endtask

  task automatic test_abort();
    set_stim(2'd2, 2'd3, 2'd1, 2'd2);
    abort_at = 2;
    restart_cyc = 2;
    run_burst(4, 8);
    checks++;
    if (done_cycle != 4 || wr_count !== 4'd3) begin
      errors++;
      $display("FAIL abort: done_cycle=%0d count=%0d expected 4 and 3", done_cycle, wr_count);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b done=%b expected 0 and 0", busy, done);
    end
    test_readback("abort");
  endtask

  task automatic test_reset_mid_burst();
    set_stim(2'd1, 2'd2, 2'd3, 2'd0);
    @(negedge clk);
    start = 1'b1; base_addr = 3'd3; len = 4'd5;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b0; wr_valid = 1'b1; wr_data = stim_words[k];
      model_mem[3 + k] = stim_words[k];
      model_known[3 + k] = 1'b1;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, wr_ready, wr_count, rd_data} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b ready=%b count=%0d rd=%0d expected all 0",
               busy, done, wr_ready, wr_count, rd_data);
    end
`ifdef WRITER_CHECKSUM_EN
    checks++;
    if (checksum !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_checksum: got %0d expected 0", checksum);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    test_readback("reset_mid");
  endtask

  task automatic test_checksum_words();
    set_stim(2'd1, 2'd2, 2'd3, 2'd0);
    run_burst(0, 3);
    checks++;
    if (done_cycle != 4 || wr_count !== 4'd3) begin
      errors++;
      $display("FAIL csum_burst: done_cycle=%0d count=%0d expected 4 and 3", done_cycle, wr_count);
    end
`ifdef WRITER_CHECKSUM_EN
    checks++;
    if (checksum !== 2'd0) begin
      errors++;
      $display("FAIL checksum_123: got %0d expected 0", checksum);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = 2'd0;
      model_known[i] = 1'b0;
    end
    test_reset();
    test_fill_all();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_abort();
    test_reset_mid_burst();
    test_checksum_words();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
